// File: rtl/mux_burst_arbiter_if.sv
// Bus between the burst arbiter and its two requesters, the shared 2:1 mux and the downstream consumer.
// req is a level request; gnt stays high for the whole burst; a beat moves whenever gnt & ~stall.
interface mux_burst_arbiter_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    logic             req0;
    logic             req1;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             stall;
    logic             mux_msb;
    logic             gnt0;
    logic             gnt1;
    logic             adv0;
    logic             adv1;
    logic             mux_sel;
    logic             mux_ce;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] neg_cnt;

    modport master (
        input  req0, req1, len0, len1, stall, mux_msb,
        output gnt0, gnt1, adv0, adv1, mux_sel, mux_ce,
        output out_valid, out_last, busy, neg_cnt
    );

    modport slave (
        output req0, req1, len0, len1, stall, mux_msb,
        input  gnt0, gnt1, adv0, adv1, mux_sel, mux_ce,
        input  out_valid, out_last, busy, neg_cnt
    );
endinterface

// File: rtl/mux_burst_arbiter.sv
// Round-robin burst arbiter driving the registered 2:1 datapath mux (sel/ce) with aligned valid/last.
// Optional NEG_COUNT_EN adds a per-burst counter of valid words whose sign bit is set.
module mux_burst_arbiter #(
    parameter int LEN_W   = 8,
    parameter int GAP_CYC = 1,
    parameter int CNT_W   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    mux_burst_arbiter_if.master   bus,
    output logic [1:0]            state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    state_t           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [3:0]       gap_q;
    logic             ptr_q;
    logic             sel_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic any_req;
    logic win_c;
    logic beat;
    logic grant_c;

    // Both requesting: the source that did not win last time gets the mux.
    assign any_req = bus.req0 | bus.req1;
    assign win_c   = (bus.req0 & bus.req1) ? ~ptr_q : bus.req1;
    assign grant_c = (state_q == IDLE) & any_req;
    assign beat    = (state_q == BURST) & ~bus.stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            ptr_q       <= 1'b1;
            sel_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= beat;
            out_last_q  <= beat & (cnt_q == '0);
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q   <= win_c;
                        gnt0_q  <= ~win_c;
                        gnt1_q  <= win_c;
                        cnt_q   <= win_c ? bus.len1 : bus.len0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (!bus.stall) begin
                        if (cnt_q == '0) begin
                            ptr_q  <= sel_q;
                            gnt0_q <= 1'b0;
                            gnt1_q <= 1'b0;
                            if (GAP_CYC > 0) begin
                                gap_q   <= GAP_LOAD;
                                state_q <= GAP;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.adv0      = gnt0_q & ~bus.stall;
    assign bus.adv1      = gnt1_q & ~bus.stall;
    assign bus.mux_sel   = sel_q;
    assign bus.mux_ce    = beat;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != IDLE);
    assign state_o       = state_q;

`ifdef NEG_COUNT_EN
    logic [CNT_W-1:0] neg_q;

    // The word sampled here is the one out_valid qualifies, so msb is read one cycle after its ce.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            neg_q <= '0;
        end else if (grant_c) begin
            neg_q <= '0;
        end else if (out_valid_q && bus.mux_msb && (neg_q != '1)) begin
            neg_q <= neg_q + 1'b1;
        end
    end

    assign bus.neg_cnt = neg_q;
`else
    logic unused_neg;
    assign unused_neg  = bus.mux_msb | grant_c;
    assign bus.neg_cnt = '0;
`endif
endmodule

// File: tb/tb_mux_burst_arbiter.sv
// Randomised and directed checks of mux_burst_arbiter against a words-remaining reference model.
module tb_mux_burst_arbiter;
    localparam int LEN_W   = 8;
    localparam int CNT_W   = 8;
    localparam int GAP_CYC = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    mux_burst_arbiter_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    mux_burst_arbiter #(
        .LEN_W  (LEN_W),
        .GAP_CYC(GAP_CYC),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int         owner      = -1;   // source holding the mux, -1 when none
    int         words_left = 0;
    int         gap_left   = 0;
    int         ptr        = 1;
    bit         sel_m      = 1'b0;
    int         neg_m      = 0;
    logic [1:0] exp_q[$];          // {valid,last} the output register will show next

    // ---------------- monitor counters ----------------
    int n_gnt0, n_gnt1, n_ce, n_valid, n_last, cyc, first_ce, first_v;
    int gq_src[$];
    int gq_cyc[$];
    bit prev_g0, prev_g1;

    task automatic model_reset();
        owner      = -1;
        words_left = 0;
        gap_left   = 0;
        ptr        = 1;
        sel_m      = 1'b0;
        neg_m      = 0;
        exp_q.delete();
        exp_q.push_back(2'b00);
    endtask

    task automatic clear_mon();
        n_gnt0 = 0; n_gnt1 = 0; n_ce = 0; n_valid = 0; n_last = 0;
        cyc = 0; first_ce = -1; first_v = -1;
        gq_src.delete();
        gq_cyc.delete();
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // ---------------- scoreboard: compare every cycle, then advance model ----------------
    always @(negedge clk) begin
        logic [8:0] exp_v;
        logic [8:0] act_v;
        logic [1:0] vl;
        int         w;
        int         exp_neg;
        bit         beat_m;
        bit         granting;

        if (!rst_n) model_reset();
        vl = exp_q[0];
        exp_v = {owner == 0, owner == 1,
                 (owner == 0) && !bus.stall, (owner == 1) && !bus.stall,
                 sel_m, (owner >= 0) && !bus.stall,
                 vl[1], vl[0], (owner >= 0) || (gap_left > 0)};
        act_v = {bus.gnt0, bus.gnt1, bus.adv0, bus.adv1, bus.mux_sel, bus.mux_ce,
                 bus.out_valid, bus.out_last, bus.busy};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL outputs t=%0t {g0,g1,a0,a1,sel,ce,v,l,busy} got=%b want=%b",
                     $time, act_v, exp_v);
        end
`ifdef NEG_COUNT_EN
        exp_neg = neg_m;
`else
        exp_neg = 0;
`endif
        total++;
        if (32'(bus.neg_cnt) != exp_neg) begin
            bad++;
            $display("FAIL neg_cnt t=%0t got=%0d want=%0d", $time, bus.neg_cnt, exp_neg);
        end

        cyc++;
        if (bus.gnt0) n_gnt0++;
        if (bus.gnt1) n_gnt1++;
        if (bus.mux_ce) begin
            n_ce++;
            if (first_ce < 0) first_ce = cyc;
        end
        if (bus.out_valid) begin
            n_valid++;
            if (first_v < 0) first_v = cyc;
        end
        if (bus.out_last) n_last++;
        if (bus.gnt0 && !prev_g0) begin gq_src.push_back(0); gq_cyc.push_back(cyc); end
        if (bus.gnt1 && !prev_g1) begin gq_src.push_back(1); gq_cyc.push_back(cyc); end
        prev_g0 = bus.gnt0;
        prev_g1 = bus.gnt1;

        if (rst_n) begin
            beat_m   = (owner >= 0) && !bus.stall;
            granting = (owner < 0) && (gap_left == 0) && (bus.req0 || bus.req1);
            void'(exp_q.pop_front());
            exp_q.push_back({beat_m, beat_m && (words_left == 1)});
            if (granting) neg_m = 0;
            else if (vl[1] && bus.mux_msb && neg_m < (2 ** CNT_W - 1)) neg_m++;
            if (owner >= 0) begin
                if (beat_m) begin
                    words_left--;
                    if (words_left == 0) begin
                        ptr      = owner;
                        owner    = -1;
                        gap_left = GAP_CYC;
                    end
                end
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (granting) begin
                w          = (bus.req0 && bus.req1) ? 1 - ptr : (bus.req0 ? 0 : 1);
                owner      = w;
                sel_m      = w[0];
                words_left = (w == 1 ? int'(bus.len1) : int'(bus.len0)) + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.stall = 1'b0; bus.mux_msb = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.len0 = '0;   bus.len1 = '0;
        bus.stall = 1'b0; bus.mux_msb = 1'b0;
        model_reset();
        clear_mon();
        step(1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_gnt", int'(bus.gnt0 | bus.gnt1), 0);

        // single 4-word burst from source 0
        do_reset(); clear_mon();
        bus.len0 = 8'd3; bus.req0 = 1'b1;
        step(1); bus.req0 = 1'b0;
        step(10);
        check("b4_gnt0", n_gnt0, 4);
        check("b4_gnt1", n_gnt1, 0);
        check("b4_ce", n_ce, 4);
        check("b4_valid", n_valid, 4);
        check("b4_last", n_last, 1);
        check("b4_valid_lag", first_v - first_ce, 1);

        // both requesting, len 0: alternate grants every 3 cycles, source 0 first
        do_reset(); clear_mon();
        bus.len0 = 8'd0; bus.len1 = 8'd0; bus.req0 = 1'b1; bus.req1 = 1'b1;
        step(12);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step(6);
        check("rr_grants", gq_src.size(), 4);
        if (gq_src.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("rr_src%0d", i), gq_src[i], i % 2);
            for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), gq_cyc[i] - gq_cyc[i-1], 3);
        end

        // source 1, 3 words, stalled 2 cycles on the second burst cycle
        do_reset(); clear_mon();
        bus.len1 = 8'd2; bus.req1 = 1'b1;
        step(1); bus.req1 = 1'b0;
        step(1); bus.stall = 1'b1;
        step(2); bus.stall = 1'b0;
        step(8);
        check("st_gnt1", n_gnt1, 5);
        check("st_ce", n_ce, 3);
        check("st_valid", n_valid, 3);
        check("st_last", n_last, 1);

        // reset asserted during second beat of an 8-word burst
        do_reset(); clear_mon();
        bus.len0 = 8'd7; bus.req0 = 1'b1;
        step(1); bus.req0 = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        check("ar_gnt0", int'(bus.gnt0), 0);
        check("ar_valid", int'(bus.out_valid), 0);
        check("ar_ce", int'(bus.mux_ce), 0);
        check("ar_busy", int'(bus.busy), 0);
        step(2);
        rst_n = 1'b1; clear_mon();
        bus.len1 = 8'd0; bus.req1 = 1'b1;
        step(1); bus.req1 = 1'b0;
        step(6);
        check("ar_post_gnt1", n_gnt1, 1);
        check("ar_post_gnt0", n_gnt0, 0);
        check("ar_post_valid", n_valid, 1);
        check("ar_post_last", n_last, 1);

        // sign-bit counting over a 5-word burst
        do_reset(); clear_mon();
        bus.len0 = 8'd4; bus.req0 = 1'b1;
        step(1); bus.req0 = 1'b0; bus.mux_msb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            bus.mux_msb = pat[i];
        end
        step(1);
        bus.mux_msb = 1'b0;
`ifdef NEG_COUNT_EN
        check("neg_end", int'(bus.neg_cnt), 3);
`else
        check("neg_end", int'(bus.neg_cnt), 0);
`endif
        step(2);
        bus.len1 = 8'd0; bus.req1 = 1'b1;
        step(1); bus.req1 = 1'b0;
        check("neg_clear", int'(bus.neg_cnt), 0);
        step(4);

        // maximum burst length
        do_reset(); clear_mon();
        bus.len0 = 8'd255; bus.req0 = 1'b1;
        step(1); bus.req0 = 1'b0;
        step(262);
        check("max_valid", n_valid, 256);
        check("max_last", n_last, 1);
        check("max_gnt0", n_gnt0, 256);
        check("max_busy", int'(bus.busy), 0);

        // randomised traffic checked cycle by cycle against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bus.req0    = ($urandom_range(0, 2) != 0);
            bus.req1    = ($urandom_range(0, 2) != 0);
            bus.len0    = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
            bus.len1    = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
            bus.stall   = ($urandom_range(0, 3) == 0);
            bus.mux_msb = 1'($urandom_range(0, 1));
            rst_n       = ($urandom_range(0, 599) != 0);
            step(1);
        end
        rst_n = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.stall = 1'b0;
        step(300);
        check("end_idle", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
